// File: rtl/pe_bus_receiver_pkg.sv
// Shared bus constants used by the bus master and every PE receiver.
// The full-threshold helper keeps master and receiver agreeing on the slack formula.
package pe_bus_receiver_pkg;

    localparam int BUS_NUM_PE     = 8;
    localparam int BUS_DATA_LEN   = 16;
    localparam int BUS_ADDR_W     = 3;
    localparam int BUS_FIFO_DEPTH = 4;
    localparam int BUS_LATENCY    = 1;
    localparam int BUS_FULL_SLACK = 2;

    // Occupancy at which a source must be throttled so in-flight grants still fit.
    function automatic int full_threshold(input int depth, input int slack);
        return depth - slack;
    endfunction

endpackage

// File: rtl/bus_rx_fifo.sv
// Single-source receive FIFO: power-of-two depth, wrapping pointers, pop-before-push
// so a full FIFO can accept a word in the same cycle one leaves.
module bus_rx_fifo #(
    parameter int DATA_LEN   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_LEN-1:0]         din,
    output logic [DATA_LEN-1:0]         dout,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_LEN-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // An empty FIFO never pops, so a same-cycle push becomes visible next cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pe_bus_receiver.sv
// PE-side receiver for the shared bus: delays the read strobe to the data cycle,
// steers captured words into per-source FIFOs and reports per-source back-pressure.
module pe_bus_receiver
    import pe_bus_receiver_pkg::*;
#(
    parameter int NUM_PE       = BUS_NUM_PE,
    parameter int DATA_LEN     = BUS_DATA_LEN,
    parameter int BUS_ADDR_LEN = BUS_ADDR_W,
    parameter int FIFO_DEPTH   = BUS_FIFO_DEPTH,
    parameter int BUS_LAT      = BUS_LATENCY,
    parameter int FULL_SLACK   = BUS_FULL_SLACK
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    rd_from_bus,
    input  logic [DATA_LEN-1:0]     data_bus,
    input  logic [BUS_ADDR_LEN-1:0] addr_bus,
    output logic [NUM_PE-1:0]       rd_buffer_full,
    input  logic                    pop_req,
    input  logic [BUS_ADDR_LEN-1:0] pop_src,
    output logic [DATA_LEN-1:0]     pop_data,
    output logic                    pop_valid,
    output logic [NUM_PE-1:0]       not_empty,
    output logic                    overflow_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(BUS_LAT + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;
    localparam logic [SW-1:0] FULL_THRESH = SW'(full_threshold(FIFO_DEPTH, FULL_SLACK));

    logic [BUS_LAT-1:0]  strb_q, strb_d;
    logic [IW-1:0]       inflight_q, inflight_d;
    logic                capture;
    logic [NUM_PE-1:0]   push_sel, pop_sel, fifo_full, fifo_empty;
    logic [DATA_LEN-1:0] fifo_dout [NUM_PE];
    logic [CW-1:0]       fifo_count [NUM_PE];
    logic                pop_valid_q, pop_valid_d;
    logic [DATA_LEN-1:0] pop_data_q, pop_data_d;
    logic                ovf_q, ovf_d;

    assign strb_d     = BUS_LAT'({strb_q, rd_from_bus});
    assign capture    = strb_q[BUS_LAT-1];
    // The sender is unknown until the data cycle, so every in-flight strobe counts against all sources.
    assign inflight_d = inflight_q + IW'(rd_from_bus) - IW'(capture);

    for (genvar s = 0; s < NUM_PE; s++) begin : g_src
        assign push_sel[s] = capture && (addr_bus == BUS_ADDR_LEN'(s));
        assign pop_sel[s]  = pop_req && (pop_src == BUS_ADDR_LEN'(s));

        bus_rx_fifo #(
            .DATA_LEN  (DATA_LEN),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rstn (rstn),
            .push (push_sel[s]),
            .pop  (pop_sel[s]),
            .din  (data_bus),
            .dout (fifo_dout[s]),
            .count(fifo_count[s]),
            .full (fifo_full[s]),
            .empty(fifo_empty[s])
        );

        assign rd_buffer_full[s] = (SW'(fifo_count[s]) + SW'(inflight_q)) >= FULL_THRESH;
    end

    assign not_empty = ~fifo_empty;

    always_comb begin
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        for (int s = 0; s < NUM_PE; s++) begin
            if (pop_sel[s] && !fifo_empty[s]) begin
                pop_valid_d = 1'b1;
                pop_data_d  = fifo_dout[s];
            end
        end
    end

    // A capture is lost only when its FIFO is full and not being popped in the same cycle.
    assign ovf_d = ovf_q | (|(push_sel & fifo_full & ~(pop_sel & ~fifo_empty)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            strb_q      <= '0;
            inflight_q  <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            strb_q      <= strb_d;
            inflight_q  <= inflight_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign pop_valid    = pop_valid_q;
    assign pop_data     = pop_data_q;
    assign overflow_err = ovf_q;

endmodule
